// File: rtl/timer.sv
// timer: loadable down-counter for the traffic-light controller.
//
// The controller loads a duration (seconds) with a one-edge start_timer
// strobe. The count then drops by one on every seconds_enabled tick, and
// expired rises on the edge that carries the last tick.
//
// Ports
//   clkin           system clock, rising edge
//   rst_n           asynchronous active-low reset
//   value           duration in seconds, sampled when start_timer is high
//   seconds_enabled 1 Hz tick enable (may be held high to count every clock)
//   start_timer     synchronous load/restart strobe
//   expired         level, high in EXPIRED until the next start or reset
//   busy            high while counting
//   remaining       current count
module timer #(
  parameter int WIDTH = 4
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] value,
  input  logic             seconds_enabled,
  input  logic             start_timer,
  output logic             expired,
  output logic             busy,
  output logic [WIDTH-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // start_timer wins over the tick in every state; a zero duration goes
  // straight to EXPIRED without passing through RUNNING.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (start_timer) begin
      count_nxt = value;
      state_nxt = (value != '0) ? RUNNING : EXPIRED;
    end else begin
      unique case (state)
        IDLE: ;
        RUNNING: begin
          if (seconds_enabled) begin
            // count <= 1 also covers a stray zero so the count never wraps
            if (count > WIDTH'(1)) begin
              count_nxt = count - WIDTH'(1);
            end else begin
              count_nxt = '0;
              state_nxt = EXPIRED;
            end
          end
        end
        EXPIRED: count_nxt = '0;
        default: begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      endcase
    end
  end

  // Outputs come straight off the state and count flops.
  assign remaining = count;
  assign busy      = (state == RUNNING);
  assign expired   = (state == EXPIRED);

endmodule

// File: tb/tb_timer.sv
module tb_timer;
  logic       clkin = 1'b0;
  logic       rst_n;
  logic [3:0] value;
  logic       seconds_enabled;
  logic       start_timer;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;

  int checks = 0;
  int errors = 0;

  timer #(.WIDTH(4)) dut (
    .clkin          (clkin),
    .rst_n          (rst_n),
    .value          (value),
    .seconds_enabled(seconds_enabled),
    .start_timer    (start_timer),
    .expired        (expired),
    .busy           (busy),
    .remaining      (remaining)
  );

  always #5 clkin = ~clkin;

  // advance one rising edge, land 1 time unit after it
  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; value = 4'd0; seconds_enabled = 1'b0; start_timer = 1'b0;
    #3 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      value = 4'($urandom_range(0, 15));
      seconds_enabled = 1'($urandom_range(0, 1));
      start_timer = 1'($urandom_range(0, 1));
      step();
      checks++;
      if ({expired, busy, remaining} !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold exp/busy/rem=%b/%b/%0d want 0/0/0", expired, busy, remaining);
      end
    end
    start_timer = 1'b0; seconds_enabled = 1'b1; value = 4'd9;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if ({expired, busy, remaining} !== 6'b0) begin
        errors++;
        $display("FAIL idle_after_reset cyc=%0d exp/busy/rem=%b/%b/%0d want 0/0/0", i, expired, busy, remaining);
      end
    end
  endtask

  task automatic test_basic();
    value = 4'd7; start_timer = 1'b1; seconds_enabled = 1'b1;
    step();
    start_timer = 1'b0;
    checks++;
    if (remaining !== 4'd7 || busy !== 1'b1 || expired !== 1'b0) begin
      errors++;
      $display("FAIL basic_load rem=%0d busy=%b exp=%b want 7/1/0", remaining, busy, expired);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (remaining !== 4'(7 - k) || busy !== 1'b1 || expired !== 1'b0) begin
        errors++;
        $display("FAIL basic_count k=%0d rem=%0d busy=%b exp=%b want %0d/1/0", k, remaining, busy, expired, 7 - k);
      end
    end
    step();
    checks++;
    if (expired !== 1'b1 || busy !== 1'b0 || remaining !== 4'd0) begin
      errors++;
      $display("FAIL basic_expire exp=%b busy=%b rem=%0d want 1/0/0", expired, busy, remaining);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (expired !== 1'b1 || remaining !== 4'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL basic_hold i=%0d exp=%b rem=%0d busy=%b want 1/0/0", i, expired, remaining, busy);
      end
    end
  endtask

  task automatic test_sparse();
    value = 4'd3; start_timer = 1'b1; seconds_enabled = 1'b0;
    step();
    start_timer = 1'b0;
    // ticks ride the edges of cycles 5, 10, 15 -> expired after cycle 15
    for (int c = 1; c <= 20; c++) begin
      seconds_enabled = (c % 5 == 0);
      step();
      checks++;
      if (c < 15) begin
        if (remaining !== 4'(3 - c / 5) || busy !== 1'b1 || expired !== 1'b0) begin
          errors++;
          $display("FAIL sparse_count c=%0d rem=%0d busy=%b exp=%b want %0d/1/0", c, remaining, busy, expired, 3 - c / 5);
        end
      end else begin
        if (remaining !== 4'd0 || busy !== 1'b0 || expired !== 1'b1) begin
          errors++;
          $display("FAIL sparse_expire c=%0d rem=%0d busy=%b exp=%b want 0/0/1", c, remaining, busy, expired);
        end
      end
    end
    seconds_enabled = 1'b0;
    start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    for (int c = 0; c < 30; c++) step();
    checks++;
    if (remaining !== 4'd3 || busy !== 1'b1 || expired !== 1'b0) begin
      errors++;
      $display("FAIL no_tick_hold rem=%0d busy=%b exp=%b want 3/1/0", remaining, busy, expired);
    end
  endtask

  task automatic test_zero();
    value = 4'd0; start_timer = 1'b1; seconds_enabled = 1'b0;
    step();
    start_timer = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (expired !== 1'b1 || busy !== 1'b0 || remaining !== 4'd0) begin
        errors++;
        $display("FAIL zero_dur i=%0d exp=%b busy=%b rem=%0d want 1/0/0", i, expired, busy, remaining);
      end
      seconds_enabled = 1'b1;
      step();
    end
  endtask

  task automatic test_restart();
    value = 4'd7; start_timer = 1'b1; seconds_enabled = 1'b1;
    step();
    start_timer = 1'b0;
    step(); step(); step();
    checks++;
    if (remaining !== 4'd4) begin
      errors++;
      $display("FAIL restart_pre rem=%0d want 4", remaining);
    end
    value = 4'd2; start_timer = 1'b1; seconds_enabled = 1'b1;
    step();
    start_timer = 1'b0;
    checks++;
    if (remaining !== 4'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_reload rem=%0d busy=%b want 2/1", remaining, busy);
    end
    step();
    checks++;
    if (remaining !== 4'd1 || expired !== 1'b0) begin
      errors++;
      $display("FAIL restart_tick rem=%0d exp=%b want 1/0", remaining, expired);
    end
    step();
    checks++;
    if (expired !== 1'b1 || remaining !== 4'd0) begin
      errors++;
      $display("FAIL restart_expire exp=%b rem=%0d want 1/0", expired, remaining);
    end
    value = 4'd5; start_timer = 1'b1; seconds_enabled = 1'b0;
    step();
    start_timer = 1'b0;
    checks++;
    if (expired !== 1'b0 || busy !== 1'b1 || remaining !== 4'd5) begin
      errors++;
      $display("FAIL restart_from_expired exp=%b busy=%b rem=%0d want 0/1/5", expired, busy, remaining);
    end
  endtask

  task automatic test_held_start();
    value = 4'd4; start_timer = 1'b1; seconds_enabled = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (remaining !== 4'd4 || busy !== 1'b1) begin
        errors++;
        $display("FAIL held_start i=%0d rem=%0d busy=%b want 4/1", i, remaining, busy);
      end
    end
    start_timer = 1'b0;
    step();
    checks++;
    if (remaining !== 4'd3) begin
      errors++;
      $display("FAIL held_release rem=%0d want 3", remaining);
    end
    // strobe fully between edges: must be ignored
    seconds_enabled = 1'b0; value = 4'd9;
    #2 start_timer = 1'b1;
    #3 start_timer = 1'b0;
    step();
    checks++;
    if (remaining !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_start rem=%0d busy=%b want 3/1", remaining, busy);
    end
  endtask

  task automatic test_midreset();
    value = 4'd9; start_timer = 1'b1; seconds_enabled = 1'b1;
    step();
    start_timer = 1'b0;
    step(); step(); step();
    checks++;
    if (remaining !== 4'd6 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre rem=%0d busy=%b want 6/1", remaining, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({expired, busy, remaining} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_async exp/busy/rem=%b/%b/%0d want 0/0/0", expired, busy, remaining);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({expired, busy, remaining} !== 6'b0) begin
        errors++;
        $display("FAIL midreset_idle i=%0d exp/busy/rem=%b/%b/%0d want 0/0/0", i, expired, busy, remaining);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sparse();
    test_zero();
    test_restart();
    test_held_start();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
